// File: rtl/fpu_issue_seq.sv
// fpu_issue_seq
//   Issue sequencer for a multi-cycle floating-point unit. It decodes funct5
//   of an OP-FP instruction, and for each legal op:
//     - single-cycle ops: fires the write strobe in the issue cycle.
//     - multi-cycle ops: stalls the front end, holds the op, rm and rd
//       fields, then fires the float write strobe in the final cycle.
//   Illegal funct5 values raise illegal_op for one cycle.
//
// Ports
//   clk            : clock; all state changes on its rising edge
//   reset          : asynchronous active-high reset
//   fpu_decoder_en : current instruction is OP-FP
//   funct5         : instr[31:27]
//   rm             : instr[14:12], rounding mode
//   rd             : instr[11:7], destination register
//   stall          : hold PC and instruction while high
//   op_sel         : operation select to the FPU datapath
//   rm_q           : rounding mode to the FPU datapath
//   wb_rd          : writeback destination register
//   fwb_en         : float register-file write strobe
//   iwb_en         : integer register-file write strobe
//   illegal_op     : unsupported funct5 flag
//
// Every LAT_* parameter must lie in 2..31.

module fpu_issue_seq #(
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 4,
  parameter int LAT_DIV  = 12,
  parameter int LAT_SQRT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fpu_decoder_en,
  input  logic [4:0] funct5,
  input  logic [2:0] rm,
  input  logic [4:0] rd,
  output logic       stall,
  output logic [4:0] op_sel,
  output logic [2:0] rm_q,
  output logic [4:0] wb_rd,
  output logic       fwb_en,
  output logic       iwb_en,
  output logic       illegal_op
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] r_state;
  logic [4:0] r_cnt;
  logic [4:0] r_op;
  logic [2:0] r_rm;
  logic [4:0] r_rd;

  logic       w_legal;
  logic       w_int_dst;
  logic [4:0] w_lat;
  logic       w_multi_issue;

  // funct5 decode: legality, latency and destination register file.
  always_comb begin
    w_legal   = 1'b1;
    w_int_dst = 1'b0;
    w_lat     = 5'd1;
    case (funct5)
      5'b00000, 5'b00001: w_lat = 5'(LAT_ADD);
      5'b00010:           w_lat = 5'(LAT_MUL);
      5'b00011:           w_lat = 5'(LAT_DIV);
      5'b01011:           w_lat = 5'(LAT_SQRT);
      5'b10100, 5'b11000, 5'b11100: w_int_dst = 1'b1;
      5'b00100, 5'b00101, 5'b11010, 5'b11110: w_int_dst = 1'b0;
      default:            w_legal = 1'b0;
    endcase
  end

  assign w_multi_issue = (r_state == S_IDLE) && fpu_decoder_en && w_legal &&
                         (w_lat >= 5'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_op    <= 5'd0;
      r_rm    <= 3'd0;
      r_rd    <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_multi_issue) begin
            r_op <= funct5;
            r_rm <= rm;
            r_rd <= rd;
            // The issue cycle and the DONE cycle are both part of the
            // latency, so BUSY lasts L-2 cycles.
            if (w_lat == 5'd2) begin
              r_state <= S_DONE;
              r_cnt   <= 5'd0;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= w_lat - 5'd2;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 5'd1) begin
            r_state <= S_DONE;
            r_cnt   <= 5'd0;
          end else begin
            r_cnt <= r_cnt - 5'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 5'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall      = 1'b0;
    fwb_en     = 1'b0;
    iwb_en     = 1'b0;
    illegal_op = 1'b0;
    op_sel     = funct5;
    rm_q       = rm;
    wb_rd      = rd;
    case (r_state)
      S_BUSY: begin
        op_sel = r_op;
        rm_q   = r_rm;
        wb_rd  = r_rd;
        stall  = 1'b1;
      end
      S_DONE: begin
        op_sel = r_op;
        rm_q   = r_rm;
        wb_rd  = r_rd;
        fwb_en = 1'b1;   // every multi-cycle op has a float destination
      end
      default: begin
        if (fpu_decoder_en) begin
          if (!w_legal) begin
            illegal_op = 1'b1;
          end else if (w_lat == 5'd1) begin
            iwb_en = w_int_dst;
            fwb_en = !w_int_dst;
          end else begin
            stall = 1'b1;
          end
        end
      end
    endcase
    // Reset is asynchronous, so strobes must also be masked combinationally
    // while it is held, not only after the state registers clear.
    if (reset) begin
      stall      = 1'b0;
      fwb_en     = 1'b0;
      iwb_en     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_issue_seq.sv
// Testbench for fpu_issue_seq: directed scenarios followed by random
// instruction streams, checked by a transaction-level reference model.
module tb_fpu_issue_seq;

  localparam int LA = 3;
  localparam int LM = 4;
  localparam int LD = 12;
  localparam int LS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [4:0] f = 5'd0;
  logic [2:0] rm = 3'd0;
  logic [4:0] rd = 5'd0;
  logic       stall;
  logic [4:0] op_sel;
  logic [2:0] rm_q;
  logic [4:0] wb_rd;
  logic       fwb_en;
  logic       iwb_en;
  logic       illegal_op;

  fpu_issue_seq #(
    .LAT_ADD(LA), .LAT_MUL(LM), .LAT_DIV(LD), .LAT_SQRT(LS)
  ) dut (
    .clk(clk), .reset(reset), .fpu_decoder_en(en), .funct5(f), .rm(rm),
    .rd(rd), .stall(stall), .op_sel(op_sel), .rm_q(rm_q), .wb_rd(wb_rd),
    .fwb_en(fwb_en), .iwb_en(iwb_en), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected response: kind 0 = float write, 1 = integer write, 2 = illegal.
  typedef struct {
    int         cyc;
    int         kind;
    logic [4:0] rd;
  } ev_t;
  ev_t q[$];

  int n_checks = 0;
  int n_fail = 0;

  logic       exp_stall = 1'b0;
  logic [4:0] exp_op = 5'd0;
  logic [2:0] exp_rm = 3'd0;
  logic [4:0] exp_rd = 5'd0;
  int         busy_end = -1;
  logic [4:0] l_op = 5'd0;
  logic [2:0] l_rm = 3'd0;
  logic [4:0] l_rd = 5'd0;

  logic [4:0] legal [12] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                             5'b01011, 5'b00100, 5'b00101, 5'b10100,
                             5'b11000, 5'b11010, 5'b11100, 5'b11110};

  // Latency in cycles, 0 meaning illegal.
  function automatic int lat_of(input logic [4:0] fn);
    case (fn)
      5'b00000, 5'b00001: return LA;
      5'b00010:           return LM;
      5'b00011:           return LD;
      5'b01011:           return LS;
      5'b00100, 5'b00101, 5'b10100, 5'b11000,
      5'b11010, 5'b11100, 5'b11110: return 1;
      default:            return 0;
    endcase
  endfunction

  function automatic bit is_int(input logic [4:0] fn);
    return (fn == 5'b10100) || (fn == 5'b11000) || (fn == 5'b11100);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, cyc, act, req);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model.
  // The model sees an op as occupying cycles T0..T0+L-1 and writing back
  // in its last cycle; anything offered while occupied is ignored.
  task automatic drive(input logic r, input logic e, input logic [4:0] fn,
                       input logic [2:0] m, input logic [4:0] d);
    int  lat;
    ev_t ev;
    @(posedge clk);
    #1;
    reset = r; en = e; f = fn; rm = m; rd = d;
    if (r) begin
      q.delete();
      busy_end  = -1;
      exp_stall = 1'b0;
      exp_op = fn; exp_rm = m; exp_rd = d;
    end else if (cyc <= busy_end) begin
      exp_stall = (cyc < busy_end);
      exp_op = l_op; exp_rm = l_rm; exp_rd = l_rd;
    end else begin
      exp_stall = 1'b0;
      exp_op = fn; exp_rm = m; exp_rd = d;
      if (e) begin
        lat = lat_of(fn);
        ev.cyc = cyc;
        ev.rd  = d;
        if (lat == 0) begin
          ev.kind = 2;
        end else if (lat == 1) begin
          ev.kind = is_int(fn) ? 1 : 0;
        end else begin
          ev.kind   = 0;
          ev.cyc    = cyc + lat - 1;
          busy_end  = ev.cyc;
          exp_stall = 1'b1;
          l_op = fn; l_rm = m; l_rd = d;
        end
        q.push_back(ev);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5'd0, 3'd0, 5'd0);
  endtask

  // Monitor: samples on the falling edge, compares the per-cycle controls
  // and pops an expected response whenever one is due or a strobe appears.
  int  m_kind;
  int  m_nstrb;
  bit  m_due;
  ev_t m_ev;
  always @(negedge clk) begin
    chk("stall", int'(stall), int'(exp_stall));
    chk("op_sel", int'(op_sel), int'(exp_op));
    chk("rm_q", int'(rm_q), int'(exp_rm));
    chk("wb_rd", int'(wb_rd), int'(exp_rd));
    m_nstrb = int'(fwb_en) + int'(iwb_en) + int'(illegal_op);
    chk("single_strobe", int'(m_nstrb <= 1), 1);
    m_due = (q.size() > 0) && (q[0].cyc == cyc);
    chk("strobe_when_due", int'(m_nstrb != 0), int'(m_due));
    if (m_due) begin
      m_ev = q.pop_front();
      if (m_nstrb != 0) begin
        m_kind = illegal_op ? 2 : (iwb_en ? 1 : 0);
        chk("strobe_kind", m_kind, m_ev.kind);
        chk("strobe_rd", int'(wb_rd), int'(m_ev.rd));
      end
    end
  end

  initial begin
    int         r_bit;
    int         e_bit;
    logic [4:0] fn;

    // Reset held for a few cycles.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 5'b00000, 3'd0, 5'd5);

    // fadd rd=5: stall T0-T1, write at T2.
    drive(1'b0, 1'b1, 5'b00000, 3'd1, 5'd5);
    idle(3);

    // fsgnj rd=7 then fcmp rd=3, both single-cycle, back-to-back.
    drive(1'b0, 1'b1, 5'b00100, 3'd0, 5'd7);
    drive(1'b0, 1'b1, 5'b10100, 3'd0, 5'd3);
    idle(1);

    // fdiv rd=9 with funct5/rm/rd changing from T3 onward.
    drive(1'b0, 1'b1, 5'b00011, 3'd2, 5'd9);
    drive(1'b0, 1'b1, 5'b00011, 3'd2, 5'd9);
    drive(1'b0, 1'b1, 5'b00011, 3'd2, 5'd9);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 5'b00000, 3'd4, 5'd4);
    idle(2);

    // fdiv aborted by reset at T5, then fmul issued afterwards.
    drive(1'b0, 1'b1, 5'b00011, 3'd0, 5'd10);
    idle(4);
    drive(1'b1, 1'b0, 5'd0, 3'd0, 5'd0);
    drive(1'b0, 1'b1, 5'b00010, 3'd3, 5'd11);
    idle(8);

    // Illegal funct5.
    drive(1'b0, 1'b1, 5'b01111, 3'd0, 5'd6);
    idle(1);

    // fsqrt rd=1 then fmul rd=2 held on the inputs: fmul issues at T16.
    drive(1'b0, 1'b1, 5'b01011, 3'd0, 5'd1);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 5'b00010, 3'd0, 5'd2);
    idle(5);

    // Random instruction stream with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r_bit = ($urandom_range(0, 99) == 0) ? 1 : 0;
      e_bit = ($urandom_range(0, 9) < 6) ? 1 : 0;
      if ($urandom_range(0, 4) != 0) fn = legal[$urandom_range(0, 11)];
      else fn = 5'($urandom);
      drive(r_bit[0], e_bit[0], fn, 3'($urandom), 5'($urandom));
    end

    idle(40);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue_seq.md
FPU_ISSUE_SEQ -- requirements
Module: fpu_issue_seq

Interface
REQ-001 The block SHALL expose parameter LAT_ADD, default 3, meaning cycles for fadd/fsub (funct5 00000/00001).
REQ-002 The block SHALL expose parameter LAT_MUL, default 4, meaning cycles for fmul (00010).
REQ-003 The block SHALL expose parameter LAT_DIV, default 12, meaning cycles for fdiv (00011).
REQ-004 The block SHALL expose parameter LAT_SQRT, default 16, meaning cycles for fsqrt (01011); every LAT_* SHALL lie in 2..31.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 fpu_decoder_en  input  1  current instruction is OP-FP (opcode 1010011), from the main decoder.
REQ-008 funct5  input  5  instr[31:27].
REQ-009 rm  input  3  instr[14:12] rounding mode.
REQ-010 rd  input  5  instr[11:7].
REQ-011 stall  output  1  hold PC and instruction while high.
REQ-012 op_sel  output  5  operation select to FPU datapath.
REQ-013 rm_q  output  3  rounding mode to FPU datapath.
REQ-014 wb_rd  output  5  writeback destination.
REQ-015 fwb_en  output  1  float register-file write strobe.
REQ-016 iwb_en  output  1  integer register-file write strobe.
REQ-017 illegal_op  output  1  unsupported funct5 flag.

Function
REQ-018 Legal funct5 SHALL be 00000, 00001, 00010, 00011, 01011, 00100, 00101, 10100, 11000, 11010, 11100, 11110; all others illegal.
REQ-019 Latency L SHALL be LAT_* per REQ-001..004, and 1 for every other legal funct5.
REQ-020 Integer-destination class SHALL be funct5 10100, 11000, 11100; all other legal ops are float-destination.
REQ-021 FSM states SHALL be IDLE, BUSY, DONE, plus a 5-bit down counter cnt.
REQ-022 Issue cycle T0 = IDLE with fpu_decoder_en=1.
REQ-023 In IDLE, op_sel/rm_q/wb_rd SHALL pass funct5/rm/rd through combinationally; at the T0 edge with L>=2 they SHALL be latched and held until return to IDLE.
REQ-024 L=1 legal: in T0, fwb_en or iwb_en (per class) =1 combinationally, stall=0, state stays IDLE.
REQ-025 L>=2: stall=1 in T0; at T0 edge state->DONE if L=2, else state->BUSY with cnt=L-2.
REQ-026 BUSY: stall=1; if cnt=1 next state DONE, else cnt decrements.
REQ-027 DONE (cycle T(L-1)): stall=0, fwb_en=1 (all multi-cycle ops are float-destination), next state IDLE.
REQ-028 fpu_decoder_en and funct5/rm/rd changes SHALL be ignored in BUSY and DONE.
REQ-029 Illegal funct5 in IDLE with fpu_decoder_en=1: illegal_op=1 combinationally that cycle, no stall, no writeback, state stays IDLE.
REQ-030 fpu_decoder_en=0 in IDLE: stall, fwb_en, iwb_en, illegal_op all 0.
REQ-031 An OP-FP instruction presented in the cycle after DONE SHALL be issued as a new T0 (back-to-back, no bubble).
REQ-032 fwb_en and iwb_en SHALL never both be 1, and each SHALL assert exactly once per legal issued op.

Reset
REQ-033 reset=1 SHALL immediately force state IDLE, cnt=0, latched op/rm/rd=0; while reset is high, stall, fwb_en, iwb_en and illegal_op SHALL be 0.
REQ-034 Reset during BUSY or DONE SHALL abort the op with no writeback; the first OP-FP after deassertion is a fresh T0.

Verification
REQ-035 fadd rd=5, defaults: stall=1 T0-T1; T2 stall=0, fwb_en=1, wb_rd=5; T3 IDLE.
REQ-036 fsgnj (00100) rd=7: T0 fwb_en=1, wb_rd=7, stall=0; fcmp (10100) rd=3: iwb_en=1, fwb_en=0, stall=0.
REQ-037 fdiv rd=9; funct5 driven to 00000 at T3: op_sel stays 00011, fwb_en only at T11, wb_rd=9.
REQ-038 fdiv with reset pulsed at T5: stall=0 immediately, no fwb_en through T12; fmul issued after reset writes back at its own T3.
REQ-039 funct5=01111, fpu_decoder_en=1: illegal_op=1 one cycle, stall=0, fwb_en=iwb_en=0.
REQ-040 fsqrt rd=1 then fmul rd=2 back-to-back: stall T0-T14, fwb_en T15 wb_rd=1; fmul T0=T16, fwb_en T19 wb_rd=2.
